arith_sched: RTL and testbench

Sequencer and arbiter in front of the arithmetic control block (МПД). It shares the arithmetic unit between two requesters: the order unit, which issues two-operand arithmetic orders, and the I/O unit, which issues shift orders.
- For an arithmetic order it drives the full operand sequence: clear A, fetch operand 1, C→A, fetch operand 2, C→B, order pulse, wait for answer, write back.
- For I/O it issues the shift order and waits for the answer.
- It replaces the ad-hoc pulse generation in the program unit.

---
 rtl/arith_sched_if.sv | 59 +++++
 rtl/arith_sched.sv | 203 ++++++++++++++++++++
 tb/tb_arith_sched.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arith_sched_if.sv
// arith_sched_if: bundle of every handshake line between the arithmetic scheduler
// and its neighbours (order unit, I/O unit, memory, arithmetic control block).
//
// Modports:
//   master - the scheduler: samples requests, answers and mem acknowledges,
//            drives mem requests, command/order pulses, done pulses and status.
//   slave  - the environment side of the same lines.
//
// Signal groups:
//   requesters : req_op, req_op_code[2:0], req_io, done_to_op, done_to_io,
//                err_opcode, err_timeout, busy
//   memory     : mem_rd_req, mem_rd_sel, mem_rd_done, mem_wr_req, mem_wr_done
//   control    : do_clear_a, do_mem_to_c, do_move_c_to_a, do_move_c_to_b,
//                order_add/sub/mul/div/and, order_io, ac_answer_op, ac_answer_io
interface arith_sched_if;
    logic       req_op;
    logic [2:0] req_op_code;
    logic       req_io;
    logic       mem_rd_req;
    logic       mem_rd_sel;
    logic       mem_rd_done;
    logic       mem_wr_req;
    logic       mem_wr_done;
    logic       do_clear_a;
    logic       do_mem_to_c;
    logic       do_move_c_to_a;
    logic       do_move_c_to_b;
    logic       order_add;
    logic       order_sub;
    logic       order_mul;
    logic       order_div;
    logic       order_and;
    logic       order_io;
    logic       ac_answer_op;
    logic       ac_answer_io;
    logic       done_to_op;
    logic       done_to_io;
    logic       err_opcode;
    logic       err_timeout;
    logic       busy;

    modport master (
        input  req_op, req_op_code, req_io, mem_rd_done, mem_wr_done,
               ac_answer_op, ac_answer_io,
        output mem_rd_req, mem_rd_sel, mem_wr_req, do_clear_a, do_mem_to_c,
               do_move_c_to_a, do_move_c_to_b, order_add, order_sub, order_mul,
               order_div, order_and, order_io, done_to_op, done_to_io,
               err_opcode, err_timeout, busy
    );

    modport slave (
        output req_op, req_op_code, req_io, mem_rd_done, mem_wr_done,
               ac_answer_op, ac_answer_io,
        input  mem_rd_req, mem_rd_sel, mem_wr_req, do_clear_a, do_mem_to_c,
               do_move_c_to_a, do_move_c_to_b, order_add, order_sub, order_mul,
               order_div, order_and, order_io, done_to_op, done_to_io,
               err_opcode, err_timeout, busy
    );
endinterface

// File: rtl/arith_sched.sv
// arith_sched: sequencer/arbiter sharing the arithmetic control block between the
// order unit (two-operand arithmetic orders) and the I/O unit (shift orders).
// An arithmetic order runs: clear A, read operand 1, C->A, read operand 2, C->B,
// order pulse, wait for answer, write back C. An I/O order pulses order_io and
// waits for the answer. Simultaneous requests are served round-robin.
//
// Ports:
//   clk        clock
//   reset      synchronous reset, active-high
//   sched_bus  arith_sched_if.master (requests, memory, control lines, status)
//
// Parameter TIMEOUT_CYCLES (2..255): watchdog limit for the answer wait states.
// Build option ARITH_SCHED_WATCHDOG_EN: when defined, an 8-bit watchdog aborts a
// wait state after TIMEOUT_CYCLES cycles (clear A, sticky err_timeout, done pulse);
// when undefined, wait states hang until answer or reset and err_timeout is 0.
module arith_sched #(
    parameter int unsigned TIMEOUT_CYCLES = 100
) (
    input logic           clk,
    input logic           reset,
    arith_sched_if.master sched_bus
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("arith_sched: TIMEOUT_CYCLES must be in 2..255");
    end

    typedef enum logic [12:0] {
        StIdle   = 13'h0001,
        StClr    = 13'h0002,
        StRda    = 13'h0004,
        StLda    = 13'h0008,
        StRdb    = 13'h0010,
        StLdb    = 13'h0020,
        StOrd    = 13'h0040,
        StWaita  = 13'h0080,
        StWr     = 13'h0100,
        StDoneOp = 13'h0200,
        StOrdio  = 13'h0400,
        StWaitio = 13'h0800,
        StDoneIo = 13'h1000
    } state_e;

    state_e     state_q, state_d;
    logic       first_q;    // first cycle of the current state
    logic       holdoff_q;  // one ignored IDLE cycle after a done pulse
    logic       last_io_q;  // last grant went to io
    logic [2:0] code_q;
    logic       code_ok;
    logic       grant_op, grant_io;
    logic       answered, wd_expired, wd_abort;

    assign code_ok  = (code_q <= 3'd4);
    assign grant_op = (state_q == StIdle) && !holdoff_q && sched_bus.req_op &&
                      (!sched_bus.req_io || last_io_q);
    assign grant_io = (state_q == StIdle) && !holdoff_q && sched_bus.req_io &&
                      (!sched_bus.req_op || !last_io_q);
    assign answered = ((state_q == StWaita) && sched_bus.ac_answer_op) ||
                      ((state_q == StWaitio) && sched_bus.ac_answer_io);
    // An answer arriving in the expiry cycle wins over the abort.
    assign wd_abort = wd_expired && !answered;

`ifdef ARITH_SCHED_WATCHDOG_EN
    localparam logic [7:0] WdLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wd_q;
    logic       err_timeout_q;
    logic       in_wait;

    assign in_wait = (state_q == StWaita) || (state_q == StWaitio);

    // Counter is zero in every non-wait state, so it is clear on wait entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q          <= 8'd0;
            err_timeout_q <= 1'b0;
        end else begin
            wd_q <= in_wait ? wd_q + 8'd1 : 8'd0;
            if (grant_op || grant_io) begin
                err_timeout_q <= 1'b0;
            end else if (wd_abort) begin
                err_timeout_q <= 1'b1;
            end
        end
    end

    assign wd_expired            = in_wait && (wd_q == WdLast);
    assign sched_bus.err_timeout = err_timeout_q;
`else
    assign wd_expired            = 1'b0;
    assign sched_bus.err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            first_q   <= 1'b0;
            holdoff_q <= 1'b0;
            last_io_q <= 1'b1;
            code_q    <= 3'd0;
        end else begin
            state_q   <= state_d;
            first_q   <= (state_d != state_q);
            holdoff_q <= (state_q == StDoneOp) || (state_q == StDoneIo);
            if (grant_op) begin
                code_q    <= sched_bus.req_op_code;
                last_io_q <= 1'b0;
            end else if (grant_io) begin
                last_io_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_op) begin
                    state_d = StClr;
                end else if (grant_io) begin
                    state_d = StOrdio;
                end
            end
            StClr:    state_d = code_ok ? StRda : StDoneOp;
            StRda:    if (sched_bus.mem_rd_done) state_d = StLda;
            StLda:    if (!first_q) state_d = StRdb;
            StRdb:    if (sched_bus.mem_rd_done) state_d = StLdb;
            StLdb:    if (!first_q) state_d = StOrd;
            StOrd:    state_d = StWaita;
            StWaita: begin
                if (sched_bus.ac_answer_op) begin
                    state_d = StWr;
                end else if (wd_expired) begin
                    state_d = StDoneOp;
                end
            end
            StWr:     if (sched_bus.mem_wr_done) state_d = StDoneOp;
            StDoneOp: state_d = StIdle;
            StOrdio:  state_d = StWaitio;
            StWaitio: if (sched_bus.ac_answer_io || wd_expired) state_d = StDoneIo;
            StDoneIo: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        sched_bus.mem_rd_req     = 1'b0;
        sched_bus.mem_rd_sel     = 1'b0;
        sched_bus.mem_wr_req     = 1'b0;
        sched_bus.do_clear_a     = 1'b0;
        sched_bus.do_mem_to_c    = 1'b0;
        sched_bus.do_move_c_to_a = 1'b0;
        sched_bus.do_move_c_to_b = 1'b0;
        sched_bus.order_add      = 1'b0;
        sched_bus.order_sub      = 1'b0;
        sched_bus.order_mul      = 1'b0;
        sched_bus.order_div      = 1'b0;
        sched_bus.order_and      = 1'b0;
        sched_bus.order_io       = 1'b0;
        sched_bus.done_to_op     = 1'b0;
        sched_bus.done_to_io     = 1'b0;
        sched_bus.err_opcode     = 1'b0;
        sched_bus.busy           = (state_q != StIdle);
        unique case (state_q)
            // Invalid codes pass through CLR silently on the way to DONE_OP.
            StClr: sched_bus.do_clear_a = code_ok;
            StRda: sched_bus.mem_rd_req = first_q;
            StLda: begin
                sched_bus.do_mem_to_c    = first_q;
                sched_bus.do_move_c_to_a = !first_q;
            end
            StRdb: begin
                sched_bus.mem_rd_req = first_q;
                sched_bus.mem_rd_sel = 1'b1;
            end
            StLdb: begin
                sched_bus.do_mem_to_c    = first_q;
                sched_bus.do_move_c_to_b = !first_q;
            end
            StOrd: begin
                case (code_q)
                    3'd0:    sched_bus.order_add = 1'b1;
                    3'd1:    sched_bus.order_sub = 1'b1;
                    3'd2:    sched_bus.order_mul = 1'b1;
                    3'd3:    sched_bus.order_div = 1'b1;
                    3'd4:    sched_bus.order_and = 1'b1;
                    default: ;
                endcase
            end
            // Only a watchdog abort clears A from a wait state.
            StWaita, StWaitio: sched_bus.do_clear_a = wd_abort;
            StWr: sched_bus.mem_wr_req = first_q;
            StDoneOp: begin
                sched_bus.done_to_op = 1'b1;
                sched_bus.err_opcode = !code_ok;
            end
            StOrdio:  sched_bus.order_io   = 1'b1;
            StDoneIo: sched_bus.done_to_io = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_arith_sched.sv
module tb_arith_sched;

    localparam int E_CLR = 0, E_RD0 = 1, E_RD1 = 2, E_M2C = 3, E_C2A = 4, E_C2B = 5;
    localparam int E_ADD = 6, E_SUB = 7, E_MUL = 8, E_DIV = 9, E_AND = 10, E_IO = 11;
    localparam int E_WR = 12, E_DOP = 13, E_DIO = 14, E_ERROP = 15, E_ERRTO = 16;
    localparam int E_SEL1 = 17, E_BUSY = 18, NEV = 19;

    typedef struct {
        logic [2:0] code;
        int         n;
        int         ord;
        bit         err;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int cyc = 0, total = 0, bad = 0;
    int cnt[NEV];
    int first[NEV];
    int last[NEV];
    int mpd_multi = 0, errto_ever = 0;
    int op_lat = 0, io_lat = 0, rd1_lat = 0;
    int pend_op = 0, pend_io = 0, pend_rd = 0;
    logic ans_op_r = 1'b0, ans_io_r = 1'b0, rd_done_r = 1'b0, ans_op_man = 1'b0;
    logic [NEV-1:0] ev;
    logic [9:0] mpd;

    arith_sched_if bus ();

    assign bus.ac_answer_op = ans_op_r | ans_op_man;
    assign bus.ac_answer_io = ans_io_r;
    assign bus.mem_rd_done  = (bus.mem_rd_sel && rd1_lat > 0) ? rd_done_r : bus.mem_rd_req;
    assign bus.mem_wr_done  = bus.mem_wr_req;

    arith_sched #(.TIMEOUT_CYCLES(100)) dut (
        .clk      (clk),
        .reset    (reset),
        .sched_bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] all_outs();
        return {bus.mem_rd_req, bus.mem_rd_sel, bus.mem_wr_req, bus.do_clear_a,
                bus.do_mem_to_c, bus.do_move_c_to_a, bus.do_move_c_to_b, bus.order_add,
                bus.order_sub, bus.order_mul, bus.order_div, bus.order_and, bus.order_io,
                bus.done_to_op, bus.done_to_io, bus.err_opcode, bus.err_timeout};
    endfunction

    // Responder and event log: answers driven just after posedge, outputs logged at negedge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            ans_op_r  = 1'b0;
            ans_io_r  = 1'b0;
            rd_done_r = 1'b0;
            if (pend_op > 0) begin pend_op--; if (pend_op == 0) ans_op_r = 1'b1; end
            if (pend_io > 0) begin pend_io--; if (pend_io == 0) ans_io_r = 1'b1; end
            if (pend_rd > 0) begin pend_rd--; if (pend_rd == 0) rd_done_r = 1'b1; end
            @(negedge clk);
            ev = {bus.busy, bus.mem_rd_sel, bus.err_timeout, bus.err_opcode, bus.done_to_io,
                  bus.done_to_op, bus.mem_wr_req, bus.order_io, bus.order_and, bus.order_div,
                  bus.order_mul, bus.order_sub, bus.order_add, bus.do_move_c_to_b,
                  bus.do_move_c_to_a, bus.do_mem_to_c, bus.mem_rd_req & bus.mem_rd_sel,
                  bus.mem_rd_req & ~bus.mem_rd_sel, bus.do_clear_a};
            for (int i = 0; i < NEV; i++) begin
                if (ev[i] === 1'b1) begin
                    if (cnt[i] == 0) first[i] = cyc;
                    last[i] = cyc;
                    cnt[i]++;
                end
            end
            mpd = {bus.do_clear_a, bus.do_mem_to_c, bus.do_move_c_to_a, bus.do_move_c_to_b,
                   bus.order_add, bus.order_sub, bus.order_mul, bus.order_div, bus.order_and,
                   bus.order_io};
            if ($countones(mpd) > 1) mpd_multi++;
            if (bus.err_timeout === 1'b1) errto_ever++;
            if ((bus.order_add | bus.order_sub | bus.order_mul | bus.order_div |
                 bus.order_and) === 1'b1 && op_lat > 0) pend_op = op_lat;
            if (bus.order_io === 1'b1 && io_lat > 0) pend_io = io_lat;
            if (bus.mem_rd_req === 1'b1 && bus.mem_rd_sel === 1'b1 && rd1_lat > 0)
                pend_rd = rd1_lat;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_log();
        for (int i = 0; i < NEV; i++) begin
            cnt[i]   = 0;
            first[i] = -1000;
            last[i]  = -1000;
        end
    endtask

    task automatic wait_ev(input int evi, input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            if (cnt[evi] > 0) seen = 1'b1;
        end
        chk(name, int'(seen), 1);
    endtask

    task automatic idle_gap();
        repeat (4) @(posedge clk);
    endtask

    task automatic start_op(input logic [2:0] code, input int n, output int t);
        @(posedge clk);
        #2;
        clear_log();
        op_lat          = n;
        bus.req_op_code = code;
        bus.req_op      = 1'b1;
        t               = cyc;
    endtask

    task automatic run_op(input logic [2:0] code, input int n, output int t);
        start_op(code, n, t);
        wait_ev(E_DOP, 400, "done_to_op_seen");
        bus.req_op = 1'b0;
        idle_gap();
    endtask

    vec_t vecs[7];
    int   t, rc, d;

    initial begin
        vecs[0] = '{code: 3'd0, n: 3,  ord: E_ADD, err: 1'b0};
        vecs[1] = '{code: 3'd1, n: 1,  ord: E_SUB, err: 1'b0};
        vecs[2] = '{code: 3'd2, n: 10, ord: E_MUL, err: 1'b0};
        vecs[3] = '{code: 3'd3, n: 5,  ord: E_DIV, err: 1'b0};
        vecs[4] = '{code: 3'd4, n: 2,  ord: E_AND, err: 1'b0};
        vecs[5] = '{code: 3'd6, n: 0,  ord: E_ADD, err: 1'b1};
        vecs[6] = '{code: 3'd7, n: 0,  ord: E_ADD, err: 1'b1};

        clear_log();
        reset           = 1'b1;
        bus.req_op      = 1'b0;
        bus.req_io      = 1'b0;
        bus.req_op_code = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_outputs", int'(all_outs()), 0);
        chk("reset_busy", int'(bus.busy), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("post_reset_outputs", int'(all_outs()), 0);
        chk("post_reset_busy", int'(bus.busy), 0);

        // Arithmetic orders with immediate mem, answer N cycles after the order pulse.
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].code, vecs[i].n, t);
            chk($sformatf("v%0d_done_count", i), cnt[E_DOP], 1);
            if (!vecs[i].err) begin
                chk($sformatf("v%0d_done_lat", i), first[E_DOP] - t, 10 + vecs[i].n);
                chk($sformatf("v%0d_clr_at", i), first[E_CLR] - t, 1);
                chk($sformatf("v%0d_clr_count", i), cnt[E_CLR], 1);
                chk($sformatf("v%0d_rd0_at", i), first[E_RD0] - t, 2);
                chk($sformatf("v%0d_m2c_count", i), cnt[E_M2C], 2);
                chk($sformatf("v%0d_c2a_at", i), first[E_C2A] - t, 4);
                chk($sformatf("v%0d_rd1_at", i), first[E_RD1] - t, 5);
                chk($sformatf("v%0d_c2b_at", i), first[E_C2B] - t, 7);
                chk($sformatf("v%0d_order_at", i), first[vecs[i].ord] - t, 8);
                chk($sformatf("v%0d_orders_total", i),
                    cnt[E_ADD] + cnt[E_SUB] + cnt[E_MUL] + cnt[E_DIV] + cnt[E_AND], 1);
                chk($sformatf("v%0d_wr_at", i), first[E_WR] - t, 9 + vecs[i].n);
                chk($sformatf("v%0d_err_opcode", i), cnt[E_ERROP], 0);
            end else begin
                chk($sformatf("v%0d_inv_done_lat", i), first[E_DOP] - t, 2);
                chk($sformatf("v%0d_inv_err_count", i), cnt[E_ERROP], 1);
                chk($sformatf("v%0d_inv_err_with_done", i), first[E_ERROP], first[E_DOP]);
                chk($sformatf("v%0d_inv_activity", i),
                    cnt[E_CLR] + cnt[E_RD0] + cnt[E_RD1] + cnt[E_M2C] + cnt[E_C2A] +
                    cnt[E_C2B] + cnt[E_ADD] + cnt[E_SUB] + cnt[E_MUL] + cnt[E_DIV] +
                    cnt[E_AND] + cnt[E_IO] + cnt[E_WR], 0);
            end
        end

        // Second operand read answered 5 cycles late.
        rd1_lat = 5;
        run_op(3'd0, 3, t);
        rd1_lat = 0;
        chk("rdb_req_at", first[E_RD1] - t, 5);
        chk("rdb_req_count", cnt[E_RD1], 1);
        chk("rdb_sel_cycles", cnt[E_SEL1], 6);
        chk("rdb_sel_from_req", first[E_SEL1], first[E_RD1]);
        chk("rdb_sel_contig", last[E_SEL1] - first[E_SEL1], 5);
        chk("rdb_m2c_count", cnt[E_M2C], 2);
        chk("rdb_m2c_at", last[E_M2C] - t, 11);
        chk("rdb_c2b_at", first[E_C2B] - t, 12);
        chk("rdb_done_lat", first[E_DOP] - t, 18);

`ifdef ARITH_SCHED_WATCHDOG_EN
        // mul never answered: abort after 100 wait cycles.
        run_op(3'd2, 0, t);
        chk("wd_clr_count", cnt[E_CLR], 2);
        chk("wd_clr_after_order", last[E_CLR] - first[E_MUL], 100);
        chk("wd_done_after_order", first[E_DOP] - first[E_MUL], 101);
        chk("wd_errto_with_done", first[E_ERRTO], first[E_DOP]);
        chk("wd_no_write", cnt[E_WR], 0);
        run_op(3'd0, 3, t);
        chk("wd_errto_cleared_at_grant", last[E_ERRTO] - t, 0);
        chk("wd_next_done_lat", first[E_DOP] - t, 13);
`else
        // Without the watchdog a wait state holds until the answer arrives.
        start_op(3'd2, 0, t);
        repeat (150) @(negedge clk);
        #1;
        chk("hang_busy", int'(bus.busy), 1);
        chk("hang_no_done", cnt[E_DOP], 0);
        chk("hang_clr_count", cnt[E_CLR], 1);
        @(posedge clk);
        #2;
        ans_op_man = 1'b1;
        @(posedge clk);
        #2;
        ans_op_man = 1'b0;
        wait_ev(E_DOP, 20, "hang_done_after_answer");
        bus.req_op = 1'b0;
        idle_gap();
        chk("hang_wr_count", cnt[E_WR], 1);
        chk("errto_never", errto_ever, 0);
`endif

        // Reset while waiting for the answer.
        start_op(3'd0, 0, t);
        wait_ev(E_ADD, 20, "rst_order_seen");
        repeat (3) @(posedge clk);
        #2;
        reset      = 1'b1;
        bus.req_op = 1'b0;
        rc         = cyc;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_outputs", int'(all_outs()), 0);
        @(posedge clk);
        #2;
        ans_op_man = 1'b1;
        @(posedge clk);
        #2;
        ans_op_man = 1'b0;
        repeat (20) @(posedge clk);
        chk("rst_no_done", cnt[E_DOP], 0);
        chk("rst_no_write", cnt[E_WR], 0);
        chk("rst_busy_last", last[E_BUSY] - rc, 0);

        // Tie after reset: op first, io two cycles after done_to_op, no clear on io.
        @(posedge clk);
        #2;
        clear_log();
        op_lat          = 3;
        io_lat          = 4;
        bus.req_op_code = 3'd0;
        bus.req_op      = 1'b1;
        bus.req_io      = 1'b1;
        t               = cyc;
        wait_ev(E_DOP, 100, "tie_op_done_seen");
        bus.req_op = 1'b0;
        wait_ev(E_DIO, 100, "tie_io_done_seen");
        bus.req_io = 1'b0;
        idle_gap();
        d = first[E_DOP];
        chk("tie_op_first", first[E_CLR] - t, 1);
        chk("tie_op_done_lat", d - t, 13);
        chk("tie_io_order_after_done", first[E_IO] - d, 3);
        chk("tie_io_done_lat", first[E_DIO] - first[E_IO], 5);
        chk("tie_io_order_count", cnt[E_IO], 1);
        chk("tie_clr_count", cnt[E_CLR], 1);
        chk("tie_no_clr_in_io", int'(last[E_CLR] < first[E_IO]), 1);
        chk("tie_done_io_count", cnt[E_DIO], 1);

        chk("one_command_line_per_cycle", mpd_multi, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
